// File: rtl/cursor_tracker.sv
// cursor_tracker: four debounced direction buttons move an (X,Y) cursor with
// hold-to-repeat, clamp or wrap at the edges, and a synchronous recenter.
// Ports: iVGA_CLK clock, iRST_n async active-low reset;
//        up/down/left/right raw async buttons, iCenter recenter request;
//        oX/oY cursor position, oMoved one-cycle pulse on any position change.
module cursor_tracker #(
  parameter int H_MAX        = 640,
  parameter int V_MAX        = 480,
  parameter int STEP         = 4,
  parameter int DEB_CYCLES   = 500000,
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_RATE  = 2500000,
  parameter bit WRAP         = 1'b0
) (
  input  logic                     iVGA_CLK,
  input  logic                     iRST_n,
  input  logic                     up,
  input  logic                     down,
  input  logic                     left,
  input  logic                     right,
  input  logic                     iCenter,
  output logic [$clog2(H_MAX)-1:0] oX,
  output logic [$clog2(V_MAX)-1:0] oY,
  output logic                     oMoved
);

  localparam int XW = $clog2(H_MAX);
  localparam int YW = $clog2(V_MAX);
  localparam int AW = ((XW > YW) ? XW : YW) + 1;
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int RM = (REPEAT_DELAY > REPEAT_RATE) ?
                      REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RM + 1);
  localparam logic [XW-1:0] X_C = XW'(H_MAX / 2);
  localparam logic [YW-1:0] Y_C = YW'(V_MAX / 2);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } axis_st_t;

  // channel order: 0 up, 1 down, 2 left, 3 right
  logic [3:0] raw;
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] deb;

  assign raw = {right, left, down, up};

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_deb
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;
    logic          val_q;
    logic          val_d;

    // count only while input disagrees; any agreement restarts the count
    always_comb begin
      cnt_d = '0;
      val_d = val_q;
      if (sync2_q[i] != val_q) begin
        if (cnt_q == DW'(DEB_CYCLES - 1)) begin
          val_d = sync2_q[i];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
        cnt_q <= '0;
        val_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        val_q <= val_d;
      end
    end

    assign deb[i] = val_q;
  end

  // axis 0 = X (right is +), axis 1 = Y (down is +)
  logic [1:0] pos;
  logic [1:0] neg;
  logic [1:0] stp;

  assign pos = {deb[1], deb[3]};
  assign neg = {deb[0], deb[2]};

  for (genvar a = 0; a < 2; a++) begin : g_axis
    axis_st_t      st_q;
    axis_st_t      st_d;
    logic          dir_q;
    logic          dir_d;
    logic [RW-1:0] cnt_q;
    logic [RW-1:0] cnt_d;
    logic [RW-1:0] lim;
    logic          req;
    logic          s;

    assign req = pos[a] ^ neg[a];
    assign lim = (st_q == DELAY) ? RW'(REPEAT_DELAY - 1)
                                 : RW'(REPEAT_RATE - 1);

    always_comb begin
      st_d  = st_q;
      dir_d = dir_q;
      cnt_d = cnt_q;
      s     = 1'b0;
      if (iCenter || !req) begin
        st_d  = IDLE;
        cnt_d = '0;
      end else if (st_q == IDLE || dir_q != pos[a]) begin
        // fresh press, or reversal treated as a fresh press
        s     = 1'b1;
        st_d  = DELAY;
        dir_d = pos[a];
        cnt_d = '0;
      end else if (cnt_q == lim) begin
        s     = 1'b1;
        st_d  = REPEAT;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
        st_q  <= IDLE;
        dir_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        dir_q <= dir_d;
        cnt_q <= cnt_d;
      end
    end

    assign stp[a] = s;
  end

  // one spare bit so c+STEP and c+MAX never overflow
  function automatic logic [AW-1:0] step_f(
    input logic [AW-1:0] c,
    input logic [AW-1:0] m,
    input logic          fwd
  );
    logic [AW-1:0] st;
    logic [AW-1:0] sum;
    st  = AW'(STEP);
    sum = c + st;
    if (fwd) begin
      if (WRAP) step_f = (sum >= m) ? sum - m : sum;
      else      step_f = (sum >= m - 1'b1) ? m - 1'b1 : sum;
    end else begin
      if (c >= st)   step_f = c - st;
      else if (WRAP) step_f = c + m - st;
      else           step_f = '0;
    end
  endfunction

  logic [XW-1:0] x_q;
  logic [XW-1:0] x_d;
  logic [YW-1:0] y_q;
  logic [YW-1:0] y_d;
  logic          moved_q;
  logic          moved_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (iCenter) begin
      x_d = X_C;
      y_d = Y_C;
    end else begin
      if (stp[0]) x_d = XW'(step_f(AW'(x_q), AW'(H_MAX), pos[0]));
      if (stp[1]) y_d = YW'(step_f(AW'(y_q), AW'(V_MAX), pos[1]));
    end
    moved_d = (x_d != x_q) || (y_d != y_q);
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      x_q     <= X_C;
      y_q     <= Y_C;
      moved_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      moved_q <= moved_d;
    end
  end

  assign oX     = x_q;
  assign oY     = y_q;
  assign oMoved = moved_q;

endmodule

// File: tb/tb_cursor_tracker.sv
// tb_cursor_tracker: clamp and wrap instances driven in parallel,
// checked each cycle against a behavioural model plus literal points.
module tb_cursor_tracker;

  localparam int HM = 16;
  localparam int VM = 12;
  localparam int ST = 3;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 5;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn;
  logic       ctr;
  logic [3:0] x0, x1;
  logic [3:0] y0, y1;
  logic       mv0, mv1;

  int n_chk;
  int n_fail;

  cursor_tracker #(
    .H_MAX(HM), .V_MAX(VM), .STEP(ST), .DEB_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .WRAP(1'b0)
  ) u_clamp (
    .iVGA_CLK(clk), .iRST_n(rst_n),
    .up(btn[0]), .down(btn[1]), .left(btn[2]), .right(btn[3]),
    .iCenter(ctr), .oX(x0), .oY(y0), .oMoved(mv0)
  );

  cursor_tracker #(
    .H_MAX(HM), .V_MAX(VM), .STEP(ST), .DEB_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .WRAP(1'b1)
  ) u_wrap (
    .iVGA_CLK(clk), .iRST_n(rst_n),
    .up(btn[0]), .down(btn[1]), .left(btn[2]), .right(btn[3]),
    .iCenter(ctr), .oX(x1), .oY(y1), .oMoved(mv1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [3:0] m_d1, m_d2, m_deb;
  int       m_run [4];
  bit       m_held [2];
  bit       m_hdir [2];
  int       m_age [2];
  int       mx [2];
  int       my [2];
  bit       mmv [2];

  function automatic int mvc(int c, int m, bit fwd, bit wrap);
    if (fwd) return wrap ? (c + ST) % m : ((c + ST > m - 1) ? m - 1 : c + ST);
    return wrap ? (c - ST + m) % m : ((c - ST < 0) ? 0 : c - ST);
  endfunction

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_deb = '0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    for (int a = 0; a < 2; a++) begin
      m_held[a] = 0; m_hdir[a] = 0; m_age[a] = 0;
      mx[a] = HM / 2; my[a] = VM / 2; mmv[a] = 0;
    end
  endtask

  task automatic model_step(input bit [3:0] raw, input bit c);
    bit stp [2];
    bit fwd [2];
    bit p, n;
    int nx, ny;
    for (int a = 0; a < 2; a++) begin
      p = (a == 0) ? m_deb[3] : m_deb[1];
      n = (a == 0) ? m_deb[2] : m_deb[0];
      fwd[a] = p;
      stp[a] = 0;
      if (c || p == n) begin
        m_held[a] = 0;
      end else if (!m_held[a] || m_hdir[a] != p) begin
        m_held[a] = 1; m_hdir[a] = p; m_age[a] = 0; stp[a] = 1;
      end else begin
        m_age[a]++;
        stp[a] = (m_age[a] == RD) ||
                 (m_age[a] > RD && (m_age[a] - RD) % RR == 0);
      end
    end
    for (int w = 0; w < 2; w++) begin
      nx = mx[w]; ny = my[w];
      if (c) begin
        nx = HM / 2; ny = VM / 2;
      end else begin
        if (stp[0]) nx = mvc(mx[w], HM, fwd[0], w[0]);
        if (stp[1]) ny = mvc(my[w], VM, fwd[1], w[0]);
      end
      mmv[w] = (nx != mx[w]) || (ny != my[w]);
      mx[w] = nx; my[w] = ny;
    end
    for (int i = 0; i < 4; i++) begin
      if (m_d2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_deb[i] = m_d2[i]; m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_d2 = m_d1;
    m_d1 = raw;
  endtask

  // compare on every cycle, 1 time unit after the edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) model_reset();
      else model_step(btn, ctr);
      chk("clamp_x", int'(x0), mx[0]);
      chk("clamp_y", int'(y0), my[0]);
      chk("clamp_moved", int'(mv0), int'(mmv[0]));
      chk("wrap_x", int'(x1), mx[1]);
      chk("wrap_y", int'(y1), my[1]);
      chk("wrap_moved", int'(mv1), int'(mmv[1]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic press(input int i);
    btn[i] = 1'b1;
    repeat (12) tick();
    btn[i] = 1'b0;
    repeat (10) tick();
  endtask

  task automatic center();
    ctr = 1'b1;
    tick();
    ctr = 1'b0;
    tick();
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    btn = '0; ctr = 1'b0; rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_x", int'(x0), 8);
    chk("rst_y", int'(y0), 6);
    chk("rst_moved", int'(mv0), 0);

    // right held from release of reset: first step, delay, repeat, clamp
    btn[3] = 1'b1; rst_n = 1'b1;
    repeat (7) tick();
    chk("hold_c7_x", int'(x0), 11);
    chk("hold_c7_moved", int'(mv0), 1);
    chk("hold_c7_wx", int'(x1), 11);
    repeat (20) tick();
    chk("hold_c27_x", int'(x0), 14);
    repeat (5) tick();
    chk("hold_c32_x", int'(x0), 15);
    chk("hold_c32_wx", int'(x1), 1);
    repeat (5) tick();
    chk("hold_c37_x", int'(x0), 15);
    chk("hold_c37_moved", int'(mv0), 0);
    btn[3] = 1'b0;
    repeat (10) tick();

    // wrap versus clamp at the edges
    center();
    repeat (3) press(3);
    chk("wrap_right_x", int'(x1), 1);
    chk("clamp_right_x", int'(x0), 15);
    repeat (3) press(0);
    chk("wrap_up_y", int'(y1), 9);
    chk("clamp_up_y", int'(y0), 0);

    // glitchy right never settles long enough
    center();
    for (int i = 0; i < 30; i++) begin
      btn[3] = (i % 3 != 2);
      tick();
    end
    btn[3] = 1'b0;
    repeat (8) tick();
    chk("glitch_x", int'(x0), 8);
    chk("glitch_wx", int'(x1), 8);

    // left+right cancel; releasing right makes left a new press
    btn[2] = 1'b1; btn[3] = 1'b1;
    repeat (30) tick();
    chk("both_x", int'(x0), 8);
    btn[3] = 1'b0;
    repeat (6) tick();
    chk("left_c6_x", int'(x0), 8);
    tick();
    chk("left_c7_x", int'(x0), 5);
    chk("left_c7_wx", int'(x1), 5);
    btn[2] = 1'b0;
    repeat (10) tick();

    // diagonal: both axes in the same cycle, single pulse
    center();
    btn[3] = 1'b1; btn[1] = 1'b1;
    repeat (7) tick();
    chk("diag_x", int'(x0), 11);
    chk("diag_y", int'(y0), 9);
    chk("diag_moved", int'(mv0), 1);
    tick();
    chk("diag_c8_moved", int'(mv0), 0);

    // recenter wins over the same-cycle repeat step
    repeat (18) tick();
    ctr = 1'b1;
    tick();
    ctr = 1'b0;
    chk("ctr_x", int'(x0), 8);
    chk("ctr_y", int'(y0), 6);

    // reset during repeat, buttons still held
    repeat (28) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    chk("mid_rst_x", int'(x0), 8);
    chk("mid_rst_y", int'(y0), 6);
    rst_n = 1'b1;
    repeat (6) tick();
    chk("redeb_c6_x", int'(x0), 8);
    chk("redeb_c6_y", int'(y0), 6);
    tick();
    chk("redeb_c7_x", int'(x0), 11);
    chk("redeb_c7_y", int'(y0), 9);
    chk("redeb_c7_moved", int'(mv0), 1);
    btn = '0;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
